// File: rtl/frv_exwb_buffer.sv
// frv_exwb_buffer: two-entry execute-to-writeback FIFO with operand forwarding from stored results
module frv_exwb_buffer #(
  parameter int XLEN = 32
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            flush,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_rd,
  input  logic            ex_wen,
  input  logic            ex_trap,
  input  logic [XLEN-1:0] ex_wdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic            wb_wen,
  output logic            wb_trap,
  output logic [XLEN-1:0] wb_wdata,
  input  logic [4:0]      fwd_rs1_addr,
  input  logic [4:0]      fwd_rs2_addr,
  output logic            fwd_rs1_hit,
  output logic            fwd_rs2_hit,
  output logic [XLEN-1:0] fwd_rs1_data,
  output logic [XLEN-1:0] fwd_rs2_data
);
  localparam int XL = XLEN - 1;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state;
  logic rptr, wptr;
  logic [XLEN+6:0] slot [2];
  logic [XLEN+6:0] young, old;
  logic push, pop, y1, o1, y2, o2;
  function automatic logic fwd_match(logic [XLEN+6:0] e, logic [4:0] a);
    return e[XLEN+1] && !e[XLEN] && e[XLEN+6:XLEN+2] == a && a != 5'd0;
  endfunction
  assign ex_ready = state != FULL;
  assign wb_valid = state != EMPTY;
  assign push = ex_valid && ex_ready;
  assign pop = wb_valid && wb_ready;
  always_ff @(posedge g_clk or posedge g_reset)
    if (g_reset || flush) begin
      state <= EMPTY;
      rptr <= 1'b0;
      wptr <= 1'b0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop) rptr <= ~rptr;
      if (push && !pop) state <= state == EMPTY ? ONE : FULL;
      else if (pop && !push) state <= state == FULL ? ONE : EMPTY;
    end
  always_ff @(posedge g_clk)
    if (push && !flush) slot[wptr] <= {ex_rd, ex_wen, ex_trap, ex_wdata};
  assign {wb_rd, wb_wen, wb_trap, wb_wdata} = wb_valid ? slot[rptr] : '0;
  // The last write sits just behind wptr; in FULL the older entry is at rptr.
  assign young = slot[~wptr];
  assign old = slot[rptr];
  assign y1 = wb_valid && fwd_match(young, fwd_rs1_addr);
  assign o1 = state == FULL && fwd_match(old, fwd_rs1_addr);
  assign y2 = wb_valid && fwd_match(young, fwd_rs2_addr);
  assign o2 = state == FULL && fwd_match(old, fwd_rs2_addr);
  assign fwd_rs1_hit = y1 || o1;
  assign fwd_rs2_hit = y2 || o2;
  assign fwd_rs1_data = y1 ? young[XL:0] : o1 ? old[XL:0] : '0;
  assign fwd_rs2_data = y2 ? young[XL:0] : o2 ? old[XL:0] : '0;
endmodule

// File: tb/tb_frv_exwb_buffer.sv
// tb_frv_exwb_buffer: directed scenarios plus randomized traffic checked against a queue model
module tb_frv_exwb_buffer;
  localparam int XLEN = 32;
  logic g_clk = 1'b0, g_reset = 1'b1, flush = 1'b0, ex_valid = 1'b0, ex_wen = 1'b0, ex_trap = 1'b0, wb_ready = 1'b0;
  logic [4:0] ex_rd = '0, fwd_rs1_addr = '0, fwd_rs2_addr = '0;
  logic [XLEN-1:0] ex_wdata = '0;
  logic ex_ready, wb_valid, wb_wen, wb_trap, fwd_rs1_hit, fwd_rs2_hit;
  logic [4:0] wb_rd;
  logic [XLEN-1:0] wb_wdata, fwd_rs1_data, fwd_rs2_data;
  typedef struct packed {logic [4:0] rd; logic wen; logic trap; logic [XLEN-1:0] wdata;} ent_t;
  ent_t q[$];
  int checks = 0, failures = 0;

  frv_exwb_buffer #(.XLEN(XLEN)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_trap(ex_trap), .ex_wdata(ex_wdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_trap(wb_trap),
    .wb_wdata(wb_wdata), .fwd_rs1_addr(fwd_rs1_addr), .fwd_rs2_addr(fwd_rs2_addr),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit), .fwd_rs1_data(fwd_rs1_data),
    .fwd_rs2_data(fwd_rs2_data)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN:0] model_fwd(logic [4:0] a);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].wen && !q[i].trap && q[i].rd == a && a != 5'd0) return {1'b1, q[i].wdata};
    return '0;
  endfunction

  task automatic check_model();
    ent_t h;
    logic [XLEN:0] f1, f2;
    h = q.size() > 0 ? q[0] : '0;
    f1 = model_fwd(fwd_rs1_addr);
    f2 = model_fwd(fwd_rs2_addr);
    chk("ex_ready", 64'(ex_ready), 64'(q.size() < 2));
    chk("wb_valid", 64'(wb_valid), 64'(q.size() > 0));
    chk("wb_head", 64'({wb_rd, wb_wen, wb_trap, wb_wdata}), 64'(h));
    chk("fwd_rs1", 64'({fwd_rs1_hit, fwd_rs1_data}), 64'(f1));
    chk("fwd_rs2", 64'({fwd_rs2_hit, fwd_rs2_data}), 64'(f2));
  endtask

  task automatic drive(logic v, logic [4:0] rd, logic wen, logic trap, logic [XLEN-1:0] d, logic rdy, logic fl);
    ex_valid = v; ex_rd = rd; ex_wen = wen; ex_trap = trap; ex_wdata = d; wb_ready = rdy; flush = fl;
  endtask

  task automatic cyc();
    bit push, pop;
    #1 check_model();
    @(posedge g_clk);
    if (flush) q.delete();
    else begin
      push = ex_valid && q.size() < 2;
      pop = q.size() > 0 && wb_ready;
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{ex_rd, ex_wen, ex_trap, ex_wdata});
    end
    @(negedge g_clk);
  endtask

  initial begin
    #1;
    chk("rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_data", 64'({wb_rd, wb_wen, wb_trap, wb_wdata}), 64'd0);
    chk("rst_hit", 64'({fwd_rs1_hit, fwd_rs2_hit}), 64'd0);
    @(negedge g_clk); @(negedge g_clk);
    g_reset = 1'b0;
    // single push, held at the head with forwarding
    drive(1, 5'd5, 1, 0, 32'h1234, 0, 0); fwd_rs1_addr = 5'd5; cyc();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("s1_wb_valid", 64'(wb_valid), 64'd1);
    chk("s1_wb_rd", 64'(wb_rd), 64'd5);
    chk("s1_hit", 64'(fwd_rs1_hit), 64'd1);
    chk("s1_data", 64'(fwd_rs1_data), 64'h1234);
    drive(0, 0, 0, 0, 0, 0, 1); cyc();
    // two pushes to the same rd, then ordered drain
    fwd_rs1_addr = 5'd7;
    drive(1, 5'd7, 1, 0, 32'hA, 0, 0); cyc();
    drive(1, 5'd7, 1, 0, 32'hB, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 1, 0); #1;
    chk("s2_ex_ready", 64'(ex_ready), 64'd0);
    chk("s2_fwd", 64'(fwd_rs1_data), 64'hB);
    chk("s2_head_a", 64'(wb_wdata), 64'hA);
    cyc(); #1;
    chk("s2_head_b", 64'(wb_wdata), 64'hB);
    cyc(); #1;
    chk("s2_empty", 64'(wb_valid), 64'd0);
    // simultaneous push and pop from ONE
    drive(1, 5'd9, 1, 0, 32'h11, 0, 0); cyc();
    drive(1, 5'd10, 1, 0, 32'h22, 1, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("s3_one", 64'({ex_ready, wb_valid}), 64'b11);
    chk("s3_head", 64'({wb_rd, wb_wdata}), 64'({5'd10, 32'h22}));
    // flush from FULL discards incoming entry
    drive(1, 5'd1, 1, 0, 32'h33, 0, 0); cyc();
    fwd_rs1_addr = 5'd3;
    drive(1, 5'd3, 1, 0, 32'h44, 1, 1); cyc();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("s4_flush", 64'({wb_valid, ex_ready, fwd_rs1_hit}), 64'b010);
    // forwarding rejections
    fwd_rs1_addr = 5'd0; fwd_rs2_addr = 5'd4;
    drive(1, 5'd0, 1, 0, 32'h55, 0, 0); cyc();
    drive(1, 5'd4, 1, 1, 32'h66, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("s5_rd0_trap", 64'({fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data}), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 1); cyc();
    fwd_rs1_addr = 5'd6;
    drive(1, 5'd6, 0, 0, 32'h77, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("s5_wen0", 64'({fwd_rs1_hit, fwd_rs1_data}), 64'd0);
    // asynchronous reset while FULL
    drive(1, 5'd8, 1, 0, 32'h88, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 g_reset = 1'b1;
    #1;
    chk("s6_async", 64'({wb_valid, ex_ready}), 64'b01);
    q.delete();
    @(negedge g_clk); g_reset = 1'b0;
    drive(1, 5'd2, 1, 0, 32'h99, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("s6_first_push", 64'({wb_valid, wb_rd}), 64'({1'b1, 5'd2}));
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom % 4) != 0, 5'($urandom % 8), ($urandom % 4) != 0, ($urandom % 6) == 0,
            $urandom, ($urandom % 3) != 0, ($urandom % 32) == 0);
      fwd_rs1_addr = 5'($urandom % 8);
      fwd_rs2_addr = 5'($urandom % 8);
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frv_exwb_buffer.md
FRV_EXWB_BUFFER -- requirements
Module: frv_exwb_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width; XL = XLEN-1.
REQ-002 SHALL have port g_clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port g_reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-005 SHALL have port ex_valid  input  1  execute stage presents a result.
REQ-006 SHALL have port ex_ready  output  1  buffer accepts a result this cycle.
REQ-007 SHALL have port ex_rd  input  5  destination register.
REQ-008 SHALL have port ex_wen  input  1  result writes the register file.
REQ-009 SHALL have port ex_trap  input  1  instruction raised a trap.
REQ-010 SHALL have port ex_wdata  input  XLEN  ALU result.
REQ-011 SHALL have ports wb_valid (output, 1), wb_ready (input, 1), wb_rd (output, 5), wb_wen (output, 1), wb_trap (output, 1) and wb_wdata (output, XLEN), forming the head entry presented to writeback.
REQ-012 SHALL have ports fwd_rs1_addr and fwd_rs2_addr (input, 5 each) for operand lookup.
REQ-013 SHALL have ports fwd_rs1_hit and fwd_rs2_hit (output, 1 each) and fwd_rs1_data and fwd_rs2_data (output, XLEN each) for forwarding results.

Function
REQ-014 SHALL store up to 2 entries {rd, wen, trap, wdata} in FIFO order.
REQ-015 SHALL implement the states EMPTY, ONE and FULL, with a 1-bit read pointer and a 1-bit write pointer into two slots.
REQ-016 SHALL push when ex_valid && ex_ready, and pop when wb_valid && wb_ready.
REQ-017 SHALL drive ex_ready = (state != FULL) from registered state only, with no combinational path from wb_ready.
REQ-018 SHALL drive wb_valid = (state != EMPTY).
REQ-019 SHALL drive wb_rd, wb_wen, wb_trap and wb_wdata from the head slot while wb_valid=1, and all-zero while wb_valid=0.
REQ-020 SHALL give 1-cycle latency: an entry pushed into EMPTY at edge N is on wb_* in the cycle after edge N.
REQ-021 SHALL apply these state transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE with the new entry at head; FULL+pop->ONE; otherwise hold.
REQ-022 SHALL increment the write pointer on push and the read pointer on pop, each wrapping 1->0.
REQ-023 SHALL make flush override push and pop: next state EMPTY, both pointers 0, and the incoming entry discarded.
REQ-024 SHALL not change slot contents on a pop without a push.
REQ-025 SHALL set fwd_rsN_hit=1 iff some valid entry has wen=1, trap=0, rd==fwd_rsN_addr and rd!=0.
REQ-026 SHALL take fwd_rsN_data from the youngest matching entry, and drive zero when there is no hit.
REQ-027 SHALL compute forwarding combinationally from stored entries only; the ex_* inputs do not participate.
REQ-028 SHALL ignore push and pop in the same cycle as flush without any error indication.

Reset
REQ-029 SHALL, while g_reset=1 (asynchronous), force state EMPTY and both pointers 0, giving ex_ready=1, wb_valid=0, wb_* all-zero and fwd_*_hit=0.
REQ-030 SHALL leave slot data contents unspecified after reset; they are not observable per REQ-019 and REQ-026.
REQ-031 SHALL, when reset is asserted mid-operation, discard all stored entries immediately without waiting for a clock edge.
REQ-032 SHALL accept a push on the first rising edge after g_reset deasserts.

Verification
REQ-033 SHALL cover this scenario: push {rd=5, wen=1, wdata=0x1234} with wb_ready=0 -> wb_valid=1 and wb_rd=5 next cycle; fwd_rs1_addr=5 gives hit=1 and data=0x1234.
REQ-034 SHALL cover this scenario: push rd=7 twice (0xA, then 0xB) with wb_ready=0 -> FULL, ex_ready=0, fwd data=0xB; then wb_ready=1 pops 0xA and then 0xB in order.
REQ-035 SHALL cover this scenario: in ONE state, push and pop in the same cycle -> state stays ONE and the head becomes the new entry.
REQ-036 SHALL cover this scenario: FULL then flush=1 with ex_valid=1 -> EMPTY next cycle, wb_valid=0, ex_ready=1, and the incoming entry is absent.
REQ-037 SHALL cover these forwarding rejections: entries with rd=0 (wen=1), trap=1, or wen=0 -> fwd hit=0 and data=0.
REQ-038 SHALL cover this scenario: assert g_reset between clock edges while FULL -> wb_valid=0 and ex_ready=1 immediately.
